cordic_iter_gen: RTL
====================

# cordic_iter_gen

Parametrised iterative CORDIC engine; successor of the fixed 18-bit unit. Adds generic data and angle widths, a per-request iteration count up to `NITER_MAX`, full-circle pre-conditioning in both modes, and valid/ready handshakes on input and output with backpressure. A request tag passes through unchanged so several channels can share one engine. It sits between the request arbiter and the result consumer of the math datapath.

## Interface
- `DW`, 16: input x/y width, signed.
- `AW`, 16: angle width, signed binary angle; −2^(AW−1) = −π, 2^(AW−2) = π/2.
- `NITER_MAX`, 16: LUT depth and maximum iterations, 1..AW.
- `TAGW`, 4: tag width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: engine can accept.
- `in_x`, `in_y` in DW: signed operands.
- `in_z` in AW: signed angle.
- `in_vec` in 1: 0 = rotation, 1 = vectoring.
- `in_niter` in clog2(NITER_MAX+1): requested iterations.
- `in_tag` in TAGW: channel tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `out_x`, `out_y` out DW+1: signed results.
- `out_z` out AW: signed angle result.
- `out_tag` out TAGW: echoed tag.

## Operation
- FSM states: IDLE, RUN, COMP (only with the macro), HOLD.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, all data outputs and `out_tag`=0.
- IDLE: `in_ready`=1. On `in_valid`, latch the pre-conditioned operands, N, and the tag; set i=0; go to RUN.
- N = clamp(`in_niter`, 1, NITER_MAX). A value of 0 runs 1 iteration; values above NITER_MAX run NITER_MAX.
- Pre-conditioning works on sign-extended DW+1 values, so negating −2^(DW−1) cannot overflow:
  - Vectoring with x<0: x←−x, y←−y, z←z+π.
  - Rotation with |z|>π/2 (top two bits of z differ): x←−x, y←−y, z←z−π.
  - All angle sums wrap modulo 2^AW.
- Iteration i:
  - Direction d=+1 if (rotation and z≥0) or (vectoring and y<0); otherwise d=−1.
  - x←x−d·(y>>>i); y←y+d·(x>>>i); z←z−d·φi.
  - Shifts are arithmetic. x/y are DW+1 wide and wrap. φi = round(atan(2^−i)/π · 2^(AW−1)).
- RUN: after iteration N−1, go to HOLD (or COMP). Output registers load on the same edge.
- HOLD: `out_valid`=1 and outputs stay stable until `out_valid`&&`out_ready`, then go to IDLE.
- `in_ready`=0 in every state except IDLE. A request is not accepted on the cycle an output is consumed.
- `in_*` changes while not accepted are ignored.

## Timing
- Accept edge E0. Iterations occur on edges E1..EN. `out_valid` rises at EN without the macro, or E(N+1) with it.
- Minimum request period is N+2 cycles (+1 with the macro), given `out_ready` held at 1.
- `rst_n` low at any point, mid-RUN or in HOLD, returns the engine to reset values immediately. The partial result is discarded.
- Backpressure has no limit. Outputs must not change while `out_valid`&&!`out_ready`.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - The COMP state multiplies x and y by K = round(0.6072529 · 2^DW) and round-half-up shifts right by DW.
  - Results land in `out_x`/`out_y`. `out_z` is unchanged. This adds 1 cycle of latency.
- Not defined: outputs carry the raw CORDIC gain (~1.6468 for N≥8), and there is no COMP state.

## Structure
- Package `cordic_pkg` contains:
  - the atan LUT function, parametrised by AW and NITER_MAX;
  - the K constant function;
  - the FSM state enum;
  - a helper for the π/2 and π encodings.
- Sub-module `cordic_gen_stage`: one combinational micro-rotation. Inputs are x, y, z, φi, i, and mode. Outputs are next x, y, z.

## Test plan
DW=AW=16, N=16, tolerance ±4 LSB.
- Rotation: x=16384, y=0, z=8192 (45°), tag=3. Expected:
  - no macro: x≈y≈19078;
  - with macro: x≈y≈11585;
  - `out_tag`=3; `out_valid` at E16 (E17 with the macro).
- Rotation: x=16384, y=0, z=−24576 (−135°). Expected without the macro: x≈−19078, y≈−19078, z≈0.
- Vectoring: x=−16384, y=0. Expected without the macro: x≈26981, y≈0, z=−32768 (π).
- Backpressure: hold `out_ready`=0 for 20 cycles. Outputs stay stable, `in_ready`=0, and a pending `in_valid` is ignored. Raise `out_ready`: handshake completes, `in_ready`=1 the next cycle.
- `in_niter`=0: `out_valid` at E1, x=16384, y=16384, z=0 for input (16384, 0, 8192), without the macro. `in_niter`=31 with NITER_MAX=16 runs 16 iterations.
- Pull `rst_n` low at E5 of a run. All outputs drop to 0 asynchronously and `in_ready`=1 after release. The next request completes correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state type, atan table entries, gain constant
// and the binary-angle encodings of pi and pi/2.
package cordic_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StComp, StHold} state_e;

  // pi scaled by 2^60, used to turn the fixed-point arctangent into binary angle units
  localparam logic [127:0] PiQ60 = 128'h3243_F6A8_885A_308D;

  // round(atan(2^-i) / pi * 2^(aw-1)); entries at or past niter_max read as zero
  function automatic logic [63:0] atan_phi(int unsigned aw, int unsigned niter_max,
                                           int unsigned i);
    logic [127:0] acc;
    logic [127:0] term;
    logic [127:0] num;
    int           shift;
    if (i >= niter_max) return '0;
    if (i == 0) return 64'(1) << (aw - 3);
    acc = '0;
    // Taylor series of atan(x) with x = 2^-i in Q60
    for (int k = 0; k < 64; k++) begin
      shift = 60 - (2 * k + 1) * int'(i);
      if (shift >= 0) begin
        term = (128'(1) << shift) / 128'(2 * k + 1);
        if (k % 2 == 0) acc = acc + term;
        else            acc = acc - term;
      end
    end
    num = (acc << (aw - 1)) + (PiQ60 >> 1);
    return 64'(num / PiQ60);
  endfunction

  // round(0.6072529 * 2^dw)
  function automatic logic [63:0] k_const(int unsigned dw);
    return ((64'd6072529 << dw) + 64'd5000000) / 64'd10000000;
  endfunction

  // pi encodes as -2^(aw-1); the raw bit pattern is 2^(aw-1)
  function automatic logic [63:0] pi_enc(int unsigned aw);
    return 64'(1) << (aw - 1);
  endfunction

  function automatic logic [63:0] half_pi_enc(int unsigned aw);
    return 64'(1) << (aw - 2);
  endfunction

endpackage

// File: rtl/cordic_gen_stage.sv
// One combinational CORDIC micro-rotation for iteration i in rotation or vectoring mode.
module cordic_gen_stage
  import cordic_pkg::*;
#(
  parameter int unsigned XW = 17,
  parameter int unsigned AW = 16,
  parameter int unsigned IW = 5
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic        [AW-1:0] i_z,
  input  logic        [AW-1:0] i_phi,
  input  logic        [IW-1:0] i_iter,
  input  logic                 i_vec,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic        [AW-1:0] o_z
);

  logic                 w_dpos;
  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  // d = +1 drives z toward zero in rotation, y toward zero in vectoring
  assign w_dpos = i_vec ? i_y[XW-1] : ~i_z[AW-1];
  assign w_xs   = i_x >>> i_iter;
  assign w_ys   = i_y >>> i_iter;

  // Apply the rotation in the selected direction; x/y/z wrap at their widths
  always_comb begin
    if (w_dpos) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_phi;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_phi;
    end
  end

endmodule

// File: rtl/cordic_iter_gen.sv
// Iterative CORDIC engine with valid/ready handshakes, per-request iteration
// count and full-circle pre-conditioning. Optional gain compensation stage is
// enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_gen
  import cordic_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 16,
  parameter int unsigned NITER_MAX = 16,
  parameter int unsigned TAGW      = 4,
  localparam int unsigned NW       = $clog2(NITER_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic signed [AW-1:0] in_z,
  input  logic                 in_vec,
  input  logic        [NW-1:0] in_niter,
  input  logic      [TAGW-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW:0]   out_x,
  output logic signed [DW:0]   out_y,
  output logic signed [AW-1:0] out_z,
  output logic      [TAGW-1:0] out_tag
);

  localparam int unsigned XW   = DW + 1;
  localparam int unsigned LutN = 2 ** NW;

  state_e               r_state, w_state_n;
  logic signed [XW-1:0] r_x, r_y, w_x_step, w_y_step, w_x_pre, w_y_pre, w_x_ext, w_y_ext;
  logic        [AW-1:0] r_z, w_z_step, w_z_pre, w_phi;
  logic        [NW-1:0] r_i, r_n, w_n_clamp;
  logic                 r_vec, w_flip, w_last;
  logic      [TAGW-1:0] r_tag;
  logic signed [XW-1:0] r_out_x, r_out_y;
  logic        [AW-1:0] r_out_z;
  logic      [TAGW-1:0] r_out_tag;
  logic        [AW-1:0] w_phi_lut [LutN];

  for (genvar g = 0; g < LutN; g++) begin : g_lut
    assign w_phi_lut[g] = AW'(atan_phi(AW, NITER_MAX, g));
  end

  assign w_phi   = w_phi_lut[r_i];
  assign w_x_ext = {in_x[DW-1], in_x};
  assign w_y_ext = {in_y[DW-1], in_y};
  // Left half-plane in vectoring, or |z| beyond pi/2 in rotation
  assign w_flip  = in_vec ? in_x[DW-1] : (in_z[AW-1] ^ in_z[AW-2]);
  assign w_last  = (r_i + NW'(1)) == r_n;

  // Pre-rotate by pi; z+pi and z-pi are the same value modulo 2^AW
  always_comb begin
    w_x_pre = w_x_ext;
    w_y_pre = w_y_ext;
    w_z_pre = in_z;
    if (w_flip) begin
      w_x_pre = -w_x_ext;
      w_y_pre = -w_y_ext;
      w_z_pre = in_z + AW'(pi_enc(AW));
    end
  end

  // Clamp requested iterations into 1..NITER_MAX
  always_comb begin
    w_n_clamp = in_niter;
    if (in_niter == '0)                    w_n_clamp = NW'(1);
    else if (in_niter > NW'(NITER_MAX))    w_n_clamp = NW'(NITER_MAX);
  end

  cordic_gen_stage #(
    .XW (XW),
    .AW (AW),
    .IW (NW)
  ) u_stage (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_phi  (w_phi),
    .i_iter (r_i),
    .i_vec  (r_vec),
    .o_x    (w_x_step),
    .o_y    (w_y_step),
    .o_z    (w_z_step)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam int unsigned        PW   = 2 * XW;
  localparam logic signed [PW-1:0] KVal = PW'(k_const(DW));
  localparam logic signed [PW-1:0] Half = PW'(1) << (DW - 1);
  logic signed [PW-1:0] w_px, w_py;
  logic signed [XW-1:0] w_x_comp, w_y_comp;
  assign w_px     = PW'(r_x) * KVal + Half;
  assign w_py     = PW'(r_y) * KVal + Half;
  assign w_x_comp = w_px[DW +: XW];
  assign w_y_comp = w_py[DW +: XW];
`endif

  // Next-state logic for the request/iterate/present sequence
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      StIdle: if (in_valid) w_state_n = StRun;
      StRun: begin
        if (w_last) begin
`ifdef CORDIC_GAIN_COMP_EN
          w_state_n = StComp;
`else
          w_state_n = StHold;
`endif
        end
      end
      StComp: w_state_n = StHold;
      StHold: if (out_ready) w_state_n = StIdle;
      default: w_state_n = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_n;
  end

  // Working registers and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_n       <= '0;
      r_vec     <= 1'b0;
      r_tag     <= '0;
      r_out_x   <= '0;
      r_out_y   <= '0;
      r_out_z   <= '0;
      r_out_tag <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_x   <= w_x_pre;
            r_y   <= w_y_pre;
            r_z   <= w_z_pre;
            r_i   <= '0;
            r_n   <= w_n_clamp;
            r_vec <= in_vec;
            r_tag <= in_tag;
          end
        end
        StRun: begin
          r_x <= w_x_step;
          r_y <= w_y_step;
          r_z <= w_z_step;
          r_i <= r_i + NW'(1);
`ifndef CORDIC_GAIN_COMP_EN
          if (w_last) begin
            r_out_x   <= w_x_step;
            r_out_y   <= w_y_step;
            r_out_z   <= w_z_step;
            r_out_tag <= r_tag;
          end
`endif
        end
        StComp: begin
`ifdef CORDIC_GAIN_COMP_EN
          r_out_x   <= w_x_comp;
          r_out_y   <= w_y_comp;
          r_out_z   <= r_z;
          r_out_tag <= r_tag;
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StHold);
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;
  assign out_tag   = r_out_tag;

endmodule
